inv_mix_col_iter: RTL and testbench
===================================

# inv_mix_col_iter

Iterative AES InvMixColumns engine for the decryption datapath. It is the inverse of the forward MixColumns stage: it accepts one 128-bit state per handshake and multiplies each 32-bit column by the inverse matrix {0e,0b,0d,09} in GF(2^8). It processes COLS_PER_CYCLE columns per clock, trading area for latency, and presents the result behind a valid/ready output register. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse cipher round loop.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values 1, 2, 4 (anything else is an elaboration error)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- i_data  input  128  state in; column c occupies bits [127-32c : 96-32c], row 0 is the MSB byte of each column
- in_valid  input  1  i_data is valid
- in_ready  output  1  block can accept a state
- o_data  output  128  transformed state, same byte layout as i_data
- out_valid  output  1  o_data is valid
- out_ready  input  1  downstream accepts o_data
- busy  output  1  high in BUSY or DONE

## Operation
- Per column (a0..a3, where a0 is the MSB byte), the outputs are:
  - o0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - o1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - o2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - o3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- GF multiply uses xtime (shift left 1, XOR 8'h1b when the bit shifted out is 1):
  - x2 = xtime(a), x4 = xtime(x2), x8 = xtime(x4)
  - 09 = x8^a, 0b = x8^x2^a, 0d = x8^x4^a, 0e = x8^x4^x2
  - All arithmetic is 8-bit with no carries.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready, load i_data into the 128-bit state register, clear the column counter, and go to BUSY.
  - BUSY: each cycle, transform the top 32·COLS_PER_CYCLE bits of the state register. Rotate the register left by 32·COLS_PER_CYCLE, inserting the results at the LSB end. Increment the counter by COLS_PER_CYCLE. When the counter reaches 4, go to DONE; column order is then restored.
  - DONE: out_valid=1 and o_data = state register, held stable until out_ready. On out_ready, go to IDLE.
- in_ready is high only in IDLE. There is no accept in BUSY or DONE, even if out_ready is high in the same cycle.
- in_valid in BUSY or DONE is ignored; i_data is not sampled.
- out_valid never drops without out_ready, and o_data never changes while out_valid=1.

## Timing
- Reset (asynchronous, any cycle including mid-BUSY): state=IDLE, counter=0, state register=0, out_valid=0, busy=0, in_ready=1, o_data=128'h0. An in-flight block is discarded; no partial output appears.
- Latency: with the accept at edge E0, out_valid rises after edge E0 + 4/COLS_PER_CYCLE (4, 2 or 1 cycles).
- Output retire: out_ready sampled high at edge Ex drops out_valid after Ex; in_ready is high after Ex.
- Next accept: possible at the edge after the retire edge.
- Throughput: one block per 4/COLS_PER_CYCLE + 2 cycles when downstream is always ready.
- Backpressure: out_ready low holds DONE indefinitely, with o_data stable.
- busy is registered from the state encoding and is glitch-free.

## Test plan
- Single vector, all COLS_PER_CYCLE values: i_data = 8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> o_data = db135345_f20a225c_01010101_d4d4d4d5. out_valid rises exactly 4, 2 or 1 cycles after the accept.
- Fixed points: i_data = {4{c6c6c6c6}} -> identical output. i_data = 4d7ebdf8_... (remaining columns 0) -> column 0 = 2d26314c, others 0.
- Backpressure: hold out_ready=0 for 10 cycles while in_valid=1 with a different i_data. Check in_ready=0, o_data unchanged, and the second block accepted only after the retire.
- Reset mid-BUSY: assert rst_n=0 one cycle after an accept. Check that all outputs immediately go to reset values, no out_valid, and the next block processes correctly.
- Round trip: 1000 random states through the forward MixColumns stage and then this block, with random in_valid/out_ready stalls. The output must equal the original state, in order, with no drops or duplicates.
- Back-to-back with out_ready tied high: issue 8 blocks and measure the spacing between out_valid pulses as 4/COLS_PER_CYCLE + 2 cycles.

Source files
------------

// File: rtl/inv_mix_col_iter_if.sv
// Stream interface for the iterative InvMixColumns engine: input handshake,
// output handshake and busy status.
interface inv_mix_col_iter_if;
   logic [127:0] i_data;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] o_data;
   logic         out_valid;
   logic         out_ready;
   logic         busy;

   modport slave (
      input  i_data, in_valid, out_ready,
      output in_ready, o_data, out_valid, busy
   );

   modport master (
      output i_data, in_valid, out_ready,
      input  in_ready, o_data, out_valid, busy
   );
endinterface

// File: rtl/inv_mix_col_iter.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per BUSY cycle,
// rotating through a 128-bit state register, result held behind valid/ready.
module inv_mix_col_iter #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   inv_mix_col_iter_if.slave bus
);

   localparam int unsigned CW    = 32 * COLS_PER_CYCLE;
   localparam int unsigned CNT_W = 3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
         $error("inv_mix_col_iter: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // One column times the inverse matrix {0e,0b,0d,09}, built from xtime chains.
   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   logic [1:0]       fsm_q, fsm_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [127:0]     sreg_q, sreg_n;
   logic             in_ready_q, in_ready_n;
   logic             out_valid_q, out_valid_n;
   logic             busy_q, busy_n;

   logic [CW-1:0]    mixed;
   logic [127:0]     rotated;

   // Transform the leading columns; results re-enter at the LSB end.
   generate
      for (genvar k = 0; k < int'(COLS_PER_CYCLE); k++) begin : g_col
         assign mixed[CW-1-32*k -: 32] = inv_col(sreg_q[127-32*k -: 32]);
      end
      if (CW == 128) begin : g_rot_full
         assign rotated = mixed;
      end else begin : g_rot_part
         assign rotated = {sreg_q[127-CW:0], mixed};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         cnt_q       <= '0;
         sreg_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_n;
         cnt_q       <= cnt_n;
         sreg_q      <= sreg_n;
         in_ready_q  <= in_ready_n;
         out_valid_q <= out_valid_n;
         busy_q      <= busy_n;
      end
   end

   always_comb begin
      fsm_n  = fsm_q;
      cnt_n  = cnt_q;
      sreg_n = sreg_q;
      case (fsm_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               sreg_n = bus.i_data;
               cnt_n  = '0;
               fsm_n  = BUSY;
            end
         end
         BUSY: begin
            sreg_n = rotated;
            cnt_n  = cnt_q + CNT_W'(COLS_PER_CYCLE);
            if (cnt_n == CNT_W'(4)) fsm_n = DONE;
         end
         DONE: begin
            if (bus.out_ready) fsm_n = IDLE;
         end
         default: fsm_n = IDLE;
      endcase
      // Status flags are registered copies of the next-state decode.
      in_ready_n  = (fsm_n == IDLE);
      out_valid_n = (fsm_n == DONE);
      busy_n      = (fsm_n == BUSY) || (fsm_n == DONE);
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.o_data    = sreg_q;

endmodule

// File: tb/tb_inv_mix_col_iter.sv
// Self-checking bench for inv_mix_col_iter: three instances (1, 2, 4 columns
// per cycle) checked against a generic GF(2^8) matrix model.
module tb_inv_mix_col_iter;

   localparam int NB = 3;
   localparam int N_RT = 1000;
   localparam logic [127:0] VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
   localparam logic [127:0] VEC_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic [127:0] i_data_v    [NB];
   logic         in_valid_v  [NB];
   logic         out_ready_v [NB];
   logic [127:0] o_data_v    [NB];
   logic         out_valid_v [NB];
   logic         in_ready_v  [NB];
   logic         busy_v      [NB];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   generate
      for (genvar k = 0; k < NB; k++) begin : g_dut
         inv_mix_col_iter_if bus ();
         inv_mix_col_iter #(.COLS_PER_CYCLE(1 << k)) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
         );
         assign bus.i_data     = i_data_v[k];
         assign bus.in_valid   = in_valid_v[k];
         assign bus.out_ready  = out_ready_v[k];
         assign o_data_v[k]    = bus.o_data;
         assign out_valid_v[k] = bus.out_valid;
         assign in_ready_v[k]  = bus.in_ready;
         assign busy_v[k]      = bus.busy;
      end
   endgenerate

   // Reference: schoolbook polynomial multiply reduced modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
      for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
      return p[7:0];
   endfunction

   // Circulant matrix product per column; inverse {0e,0b,0d,09} or forward {02,03,01,01}.
   function automatic logic [127:0] mix_state(input logic [127:0] s, input bit inverse);
      logic [7:0]   coef [4];
      logic [7:0]   a    [4];
      logic [7:0]   acc;
      logic [127:0] r;
      if (inverse) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
         for (int row = 0; row < 4; row++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc ^= gf_mul(coef[(j - row + 4) % 4], a[j]);
            r[127-32*c-8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push one block through instance 0 and retire it; lat counts cycles after accept.
   task automatic send_main(input logic [127:0] d, output logic [127:0] o, output int lat);
      int guard;
      in_valid_v[0] = 1'b1;
      i_data_v[0]   = d;
      guard = 0;
      while (!in_ready_v[0] && guard < 20) begin tick(); guard++; end
      tick();
      in_valid_v[0] = 1'b0;
      lat = 0;
      while (!out_valid_v[0] && lat < 20) begin tick(); lat++; end
      o = o_data_v[0];
      out_ready_v[0] = 1'b1;
      tick();
      out_ready_v[0] = 1'b0;
   endtask

   logic [127:0] exp_q [$];
   int           received;
   int           first [NB];
   logic [127:0] got   [NB];
   int           pulses [NB][$];

   initial begin
      logic [127:0] res, a_blk, b_blk;
      int lat, guard;

      for (int k = 0; k < NB; k++) begin
         i_data_v[k] = '0; in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
      end

      // Reset values
      #2 rst_n = 1'b0;
      #2;
      for (int k = 0; k < NB; k++) begin
         check($sformatf("rst_in_ready%0d", k),  128'(in_ready_v[k]),  128'(1));
         check($sformatf("rst_out_valid%0d", k), 128'(out_valid_v[k]), 128'(0));
         check($sformatf("rst_busy%0d", k),      128'(busy_v[k]),      128'(0));
         check($sformatf("rst_o_data%0d", k),    o_data_v[k],          128'(0));
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Known vector on all three widths, latency 4/2/1
      for (int k = 0; k < NB; k++) begin
         i_data_v[k] = VEC_IN; in_valid_v[k] = 1'b1; first[k] = -1; got[k] = '0;
      end
      tick();
      for (int k = 0; k < NB; k++) in_valid_v[k] = 1'b0;
      check("busy_after_accept", 128'(busy_v[0]), 128'(1));
      for (int cyc = 0; cyc <= 8; cyc++) begin
         for (int k = 0; k < NB; k++)
            if (out_valid_v[k] && first[k] < 0) begin first[k] = cyc; got[k] = o_data_v[k]; end
         tick();
      end
      for (int k = 0; k < NB; k++) begin
         check($sformatf("vec_latency%0d", k), 128'(first[k]), 128'(4 >> k));
         check($sformatf("vec_data%0d", k),    got[k],         VEC_OUT);
         check($sformatf("vec_hold%0d", k),    o_data_v[k],    VEC_OUT);
         out_ready_v[k] = 1'b1;
      end
      tick();
      for (int k = 0; k < NB; k++) begin
         out_ready_v[k] = 1'b0;
         check($sformatf("vec_retire%0d", k), 128'({in_ready_v[k], out_valid_v[k]}), 128'(2'b10));
      end

      // Fixed points
      send_main({4{32'hc6c6c6c6}}, res, lat);
      check("fixed_c6", res, {4{32'hc6c6c6c6}});
      send_main({32'h4d7ebdf8, 96'h0}, res, lat);
      check("fixed_col0", res, {32'h2d26314c, 96'h0});
      tick();

      // Backpressure with a competing input held valid
      a_blk = {$urandom, $urandom, $urandom, $urandom};
      b_blk = ~a_blk ^ {4{32'h5a5a0ff0}};
      in_valid_v[0] = 1'b1; i_data_v[0] = a_blk;
      tick();
      i_data_v[0] = b_blk;
      guard = 0;
      while (!out_valid_v[0] && guard < 20) begin tick(); guard++; end
      for (int c = 0; c < 10; c++) begin
         check("bp_in_ready", 128'(in_ready_v[0]),  128'(0));
         check("bp_valid",    128'(out_valid_v[0]), 128'(1));
         check("bp_hold",     o_data_v[0],          mix_state(a_blk, 1'b1));
         tick();
      end
      out_ready_v[0] = 1'b1;
      tick();
      out_ready_v[0] = 1'b0;
      check("bp_retire", 128'({in_ready_v[0], out_valid_v[0]}), 128'(2'b10));
      tick();
      in_valid_v[0] = 1'b0;
      check("bp_second_accept", 128'({busy_v[0], in_ready_v[0]}), 128'(2'b10));
      guard = 0;
      while (!out_valid_v[0] && guard < 20) begin tick(); guard++; end
      check("bp_second_data", o_data_v[0], mix_state(b_blk, 1'b1));
      out_ready_v[0] = 1'b1;
      tick();
      out_ready_v[0] = 1'b0;

      // Reset one cycle after an accept
      in_valid_v[0] = 1'b1; i_data_v[0] = {$urandom, $urandom, $urandom, $urandom};
      tick();
      in_valid_v[0] = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_state",  128'({in_ready_v[0], out_valid_v[0], busy_v[0]}), 128'(3'b100));
      check("mid_rst_o_data", o_data_v[0], 128'(0));
      tick(); tick();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         check("mid_rst_no_valid", 128'(out_valid_v[0]), 128'(0));
         tick();
      end
      send_main(VEC_IN, res, lat);
      check("post_rst_data",    res,        VEC_OUT);
      check("post_rst_latency", 128'(lat),  128'(4));

      // Round trip through forward MixColumns with random stalls
      received = 0;
      fork
         begin
            logic [127:0] s;
            int g;
            for (int i = 0; i < N_RT; i++) begin
               s = {$urandom, $urandom, $urandom, $urandom};
               repeat ($urandom_range(0, 2)) tick();
               in_valid_v[0] = 1'b1;
               i_data_v[0]   = mix_state(s, 1'b0);
               g = 0;
               while (!in_ready_v[0] && g < 100) begin tick(); g++; end
               exp_q.push_back(s);
               tick();
               in_valid_v[0] = 1'b0;
            end
         end
         begin
            int cyc;
            cyc = 0;
            while (received < N_RT && cyc < 30000) begin
               tick();
               cyc++;
               out_ready_v[0] = ($urandom_range(0, 3) != 0);
               if (out_valid_v[0] && out_ready_v[0]) begin
                  check("rt_expected", 128'(exp_q.size() != 0), 128'(1));
                  if (exp_q.size() != 0) check("rt_data", o_data_v[0], exp_q.pop_front());
                  received++;
               end
            end
            out_ready_v[0] = 1'b0;
         end
      join
      check("rt_count", 128'(received), 128'(N_RT));
      tick(); tick();

      // Back-to-back with downstream always ready
      for (int k = 0; k < NB; k++) begin in_valid_v[k] = 1'b1; out_ready_v[k] = 1'b1; end
      for (int cyc = 0; cyc < 60; cyc++) begin
         for (int k = 0; k < NB; k++) begin
            if (out_valid_v[k]) pulses[k].push_back(cyc);
            i_data_v[k] = {$urandom, $urandom, $urandom, $urandom};
         end
         tick();
      end
      for (int k = 0; k < NB; k++) begin
         check($sformatf("b2b_pulses%0d", k), 128'(pulses[k].size() >= 8), 128'(1));
         if (pulses[k].size() >= 8)
            for (int j = 1; j < 8; j++)
               check($sformatf("b2b_spacing%0d_%0d", k, j),
                     128'(pulses[k][j] - pulses[k][j-1]), 128'((4 >> k) + 2));
         in_valid_v[k] = 1'b0;
      end
      repeat (10) tick();
      for (int k = 0; k < NB; k++) begin
         out_ready_v[k] = 1'b0;
         check($sformatf("drain_idle%0d", k), 128'({in_ready_v[k], out_valid_v[k]}), 128'(2'b10));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
